// File: rtl/cmem_ctrl.sv
// Initiator for the single-port coefficient memory: streams a load set into it and
// sweeps all taps back out as an indexed coefficient stream, hiding the registered-Q latency.
module cmem_ctrl #(
  parameter int AW    = 6,
  parameter int DW    = 16,
  parameter int NTAPS = 64
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          LOAD_START,
  input  logic          LOAD_VALID,
  input  logic [DW-1:0] LOAD_DATA,
  output logic          LOAD_READY,
  output logic          LOAD_DONE,
  input  logic          SWEEP_START,
  output logic          COEF_VALID,
  output logic [DW-1:0] COEF_DATA,
  output logic [AW-1:0] COEF_IDX,
  output logic          COEF_LAST,
  output logic          BUSY,
  output logic          MEM_CEN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_A,
  output logic [DW-1:0] MEM_D,
  input  logic [DW-1:0] MEM_Q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          coef_vld_q, coef_vld_d;
  logic [AW-1:0] coef_idx_q, coef_idx_d;
  logic          load_done_q, load_done_d;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    coef_vld_d  = 1'b0;
    coef_idx_d  = coef_idx_q;
    load_done_d = 1'b0;
    LOAD_READY  = 1'b0;
    MEM_CEN     = 1'b1;
    MEM_WEN     = 1'b1;
    MEM_A       = '0;
    MEM_D       = '0;
    case (state_q)
      S_IDLE: begin
        // a simultaneous sweep request is dropped in favour of the load
        if (LOAD_START) begin
          state_d = S_LOAD;
          wptr_d  = '0;
        end else if (SWEEP_START) begin
          state_d = S_SWEEP;
          rptr_d  = '0;
        end
      end
      S_LOAD: begin
        LOAD_READY = 1'b1;
        if (LOAD_VALID) begin
          MEM_CEN = 1'b0;
          MEM_WEN = 1'b0;
          MEM_A   = wptr_q;
          MEM_D   = LOAD_DATA;
          if (wptr_q == LAST_IDX) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      S_SWEEP: begin
        MEM_CEN    = 1'b0;
        MEM_A      = rptr_q;
        coef_vld_d = 1'b1;
        coef_idx_d = rptr_q;
        if (rptr_q == LAST_IDX) state_d = S_DRAIN;
        else                    rptr_d  = rptr_q + AW'(1);
      end
      default: state_d = S_IDLE;  // DRAIN: the last read's data is emitted this cycle
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      coef_vld_q  <= 1'b0;
      coef_idx_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      coef_vld_q  <= coef_vld_d;
      coef_idx_q  <= coef_idx_d;
      load_done_q <= load_done_d;
    end
  end

  assign LOAD_DONE  = load_done_q;
  assign COEF_VALID = coef_vld_q;
  assign COEF_IDX   = coef_idx_q;
  assign COEF_DATA  = coef_vld_q ? MEM_Q : '0;
  assign COEF_LAST  = coef_vld_q & (coef_idx_q == LAST_IDX);
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmem_ctrl.sv
// Bench for cmem_ctrl: behavioural cmem model, write/coefficient scoreboards, directed steps.
module tb_cmem_ctrl;
  logic        CLK = 1'b0, RSTN = 1'b0;
  logic        LOAD_START = 1'b0, LOAD_VALID = 1'b0, SWEEP_START = 1'b0;
  logic [15:0] LOAD_DATA = '0;
  logic        LOAD_READY, LOAD_DONE, COEF_VALID, COEF_LAST, BUSY, MEM_CEN, MEM_WEN;
  logic [15:0] COEF_DATA, MEM_D;
  logic [5:0]  COEF_IDX, MEM_A;
  logic [15:0] MEM_Q = '0;

  typedef struct packed {logic [15:0] d; logic [5:0] i; logic l;} coef_t;

  coef_t       sb[$];
  logic [21:0] wq[$];
  logic [15:0] mem [64];
  logic [15:0] w [64];
  int total = 0, bad = 0, vcnt = 0, busy_cnt = 0, done_cnt = 0, gap = 0, v0 = 0;
  bit measure = 1'b0;

  cmem_ctrl #(.AW(6), .DW(16), .NTAPS(64)) dut (
    .CLK(CLK), .RSTN(RSTN), .LOAD_START(LOAD_START), .LOAD_VALID(LOAD_VALID),
    .LOAD_DATA(LOAD_DATA), .LOAD_READY(LOAD_READY), .LOAD_DONE(LOAD_DONE),
    .SWEEP_START(SWEEP_START), .COEF_VALID(COEF_VALID), .COEF_DATA(COEF_DATA),
    .COEF_IDX(COEF_IDX), .COEF_LAST(COEF_LAST), .BUSY(BUSY), .MEM_CEN(MEM_CEN),
    .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_Q(MEM_Q));

  always #5 CLK = ~CLK;

  // single-port memory with registered read data
  always @(posedge CLK) begin
    if (MEM_CEN === 1'b0) begin
      if (MEM_WEN === 1'b0) mem[MEM_A] <= MEM_D;
      else                  MEM_Q      <= mem[MEM_A];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (BUSY === 1'b1) busy_cnt++;
    if (LOAD_DONE === 1'b1) done_cnt++;
    if (MEM_CEN === 1'b0 && MEM_WEN === 1'b0) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(wq.size()), 1);
      else                chk("wr_addr_data", {10'd0, MEM_A, MEM_D}, {10'd0, wq.pop_front()});
    end
    if (COEF_VALID === 1'b1) begin
      vcnt++;
      if (measure) begin
        chk("b2b_gap", gap, 2);
        measure = 1'b0;
      end
      if (sb.size() == 0) chk("coef_unexpected", 32'(sb.size()), 1);
      else                chk("coef", {9'd0, COEF_DATA, COEF_IDX, COEF_LAST}, {9'd0, sb.pop_front()});
      if (COEF_LAST === 1'b1) gap = 0;
    end else begin
      gap++;
    end
  end

  task automatic load(input bit gapped, input bit both);
    done_cnt = 0;
    LOAD_START = 1'b1;
    SWEEP_START = both;
    @(posedge CLK); #1;
    LOAD_START = 1'b0;
    SWEEP_START = 1'b0;
    chk("load_ready", LOAD_READY, 1);
    chk("load_busy", BUSY, 1);
    for (int i = 0; i < 64; i++) begin
      if (gapped) begin
        LOAD_VALID = 1'b0;
        @(posedge CLK); #1;
        if (i == 5) chk("gap_cen", MEM_CEN, 1);
      end
      LOAD_VALID = 1'b1;
      LOAD_DATA = w[i];
      SWEEP_START = both && (i == 10);
      wq.push_back({6'(i), w[i]});
      @(posedge CLK); #1;
    end
    LOAD_VALID = 1'b0;
    SWEEP_START = 1'b0;
    chk("load_done", LOAD_DONE, 1);
    chk("ready_after", LOAD_READY, 0);
    @(posedge CLK); #1;
    chk("done_pulses", done_cnt, 1);
    chk("writes_left", 32'(wq.size()), 0);
  endtask

  task automatic sweep();
    for (int i = 0; i < 64; i++) sb.push_back({w[i], 6'(i), i == 63});
    busy_cnt = 0;
    v0 = vcnt;
    SWEEP_START = 1'b1;
    @(posedge CLK); #1;
    SWEEP_START = 1'b0;
    for (int n = 0; n < 200 && BUSY === 1'b1; n++) begin
      @(posedge CLK); #1;
    end
    chk("sweep_end_busy", BUSY, 0);
    chk("busy_cycles", busy_cnt, 65);
    chk("coef_count", vcnt - v0, 64);
    chk("coef_left", 32'(sb.size()), 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", LOAD_READY, 0);
    chk("rst_done", LOAD_DONE, 0);
    chk("rst_valid", COEF_VALID, 0);
    chk("rst_idx", COEF_IDX, 0);
    chk("rst_last", COEF_LAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cen", MEM_CEN, 1);
    chk("rst_wen", MEM_WEN, 1);
    chk("rst_a", MEM_A, 0);
    chk("rst_d", MEM_D, 0);
    RSTN = 1'b1;
    @(posedge CLK); #1;

    w[0] = 16'd350;
    for (int i = 1; i < 64; i++) w[i] = 16'(i);
    load(1'b0, 1'b0);
    sweep();

    for (int i = 0; i < 64; i++) w[i] = 16'($urandom);
    load(1'b1, 1'b0);
    sweep();

    for (int i = 0; i < 64; i++) w[i] = 16'(16'hA000 + i * 7);
    v0 = vcnt;
    load(1'b0, 1'b1);
    chk("simul_no_coef", vcnt - v0, 0);
    chk("simul_idle", BUSY, 0);
    sweep();

    for (int i = 0; i < 64; i++) sb.push_back({w[i], 6'(i), i == 63});
    SWEEP_START = 1'b1;
    @(posedge CLK); #1;
    SWEEP_START = 1'b0;
    for (int n = 0; n < 100 && !(COEF_VALID === 1'b1 && COEF_IDX == 6'd20); n++) begin
      @(posedge CLK); #1;
    end
    chk("mid_idx", COEF_IDX, 20);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    chk("mid_rst_valid", COEF_VALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_cen", MEM_CEN, 1);
    RSTN = 1'b1;
    sb.delete();
    sweep();

    sweep();
    measure = 1'b1;
    sweep();
    chk("b2b_measured", measure, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
